wr_ptr_ctrl: RTL and testbench
==============================

// Module: wr_ptr_ctrl
// PURPOSE
//  Write-domain pointer controller for the async FIFO; successor to the basic write-pointer handler.
//  Synchronises the read domain's Gray read pointer internally over SYNC_STAGES flops.
//  Produces binary/Gray write pointers, a memory write strobe, registered full, fill level,
//  programmable almost-full and a sticky overflow flag. Sits between the writer and the FIFO memory.
// PARAMETERS
//  PTR_WIDTH    3  address bits; DEPTH = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits; legal >= 2
//  SYNC_STAGES  2  flops in the read-pointer synchroniser; legal >= 2
// PORTS
//  i_clk          in   1            write-domain clock
//  i_rst          in   1            reset; asynchronous, active-high
//  i_en           in   1            write request from writer
//  i_g_rd_ptr     in   PTR_WIDTH+1  Gray read pointer, raw from read domain (unsynchronised)
//  i_af_thresh    in   PTR_WIDTH+1  almost-full threshold in words (quasi-static)
//  i_ovf_clr      in   1            clears o_overflow
//  o_wr_en        out  1            memory write strobe = i_en & ~o_full (combinational)
//  o_b_wr_ptr     out  PTR_WIDTH+1  binary write pointer; memory uses [PTR_WIDTH-1:0]
//  o_g_wr_ptr     out  PTR_WIDTH+1  Gray write pointer, registered, to read-domain sync
//  o_full         out  1            FIFO full, registered
//  o_almost_full  out  1            level >= i_af_thresh, registered
//  o_level        out  PTR_WIDTH+1  words held (write-side view, 0..DEPTH), registered
//  o_overflow     out  1            sticky: write attempted while full
// BEHAVIOUR
//  - Reset (i_rst=1, async): every flop is 0, sync chain included. All outputs are 0, o_wr_en = i_en.
//    Mid-operation reset aborts in the same instant with no partial state.
//  - Sync: rd_g_s = i_g_rd_ptr after SYNC_STAGES i_clk edges; rd_b_s = gray2bin(rd_g_s), combinational.
//  - Accept: acc = i_en & ~o_full; nxt_b = o_b_wr_ptr + acc (mod 2**(PTR_WIDTH+1));
//    nxt_g = nxt_b ^ (nxt_b>>1). Both registered every edge.
//  - Full: next o_full = (nxt_g == {~rd_g_s[MSB:MSB-1], rd_g_s[MSB-2:0]}). It asserts in the cycle
//    after the DEPTH-th accepted write. No Gray-to-binary conversion on this path.
//  - Level: next o_level = nxt_b - rd_b_s, modulo PTR_WIDTH+1 bits; always 0..DEPTH.
//  - Almost-full: next o_almost_full = (next o_level >= i_af_thresh). i_af_thresh=0 -> always 1 after
//    the first edge out of reset. i_af_thresh > DEPTH -> never asserts.
//  - Overflow: set when i_en & o_full; cleared by i_ovf_clr; set wins if both occur in one cycle.
//  - While full: pointers hold, o_wr_en=0, requests are dropped and flagged, not queued.
//  - Wrap: pointers roll DEPTH*2-1 -> 0 with no false full/level glitch; the MSB toggle carries the lap.
//  - Pessimism: the read pointer lags SYNC_STAGES+1 cycles, so full/level may overstate occupancy and
//    never understate it. full deasserts SYNC_STAGES+1 edges after the read pointer moves.
//  - Read pointer moves and write accepted in the same cycle: both are folded into one level update,
//    with no lost count.
// STRUCTURE
//  - Shared package/header: function gray2bin(), function bin2gray(), DEPTH localparam derivation.
//  - One sub-module: ptr_sync #(WIDTH, STAGES) as a flop chain with async active-high clear,
//    reused by the read-side controller.
//  - Rest is flat: pointer regs, full compare, level subtractor, flag regs.
// TESTING (PTR_WIDTH=3, DEPTH=8, SYNC_STAGES=2)
//  1 Reset: drive activity, pulse i_rst mid-burst -> all outputs 0 immediately; sync chain cleared.
//  2 Fill: i_g_rd_ptr=0, i_en=1 for 10 cycles -> o_b_wr_ptr 1..8, then holds 4'b1000, o_g_wr_ptr=4'b1100.
//    o_full=1 after the 8th accept, o_level=8, o_wr_en=0. o_overflow=1 from the 9th request.
//  3 Drain: from full, set i_g_rd_ptr=4'b0010 (bin 3) -> o_full=0 and o_level=5 exactly 3 edges later.
//  4 Almost-full: i_af_thresh=6, write from empty -> o_almost_full rises in the same cycle o_level=6,
//    and falls when reads bring o_level to 5.
//  5 Wrap: reader tracks writer at 2 words behind over 40 writes -> pointer wraps 15->0
//    (Gray 4'b1000->4'b0000), o_full never 1, o_level stays <= 2+sync lag.
//  6 Overflow clear: i_ovf_clr with a write-while-full in the same cycle -> o_overflow stays 1;
//    i_ovf_clr alone -> 0 next edge.

Source files
------------

// File: rtl/wr_ptr_ctrl_pkg.sv
// Shared pointer helpers for the async FIFO controllers: Gray/binary conversion and depth derivation.
// The conversion functions work on a 32-bit container; callers zero-extend and size-cast.
package wr_ptr_ctrl_pkg;

  function automatic int depth_of(input int ptr_width);
    return 1 << ptr_width;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits in the container stay zero, so narrow pointers convert correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/wr_ptr_ctrl_sync.sv
// Multi-flop synchroniser for a Gray pointer crossing clock domains.
// Async active-high clear. Shared with the read-side controller.
module ptr_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] ff;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ff <= '0;
    end else begin
      ff[0] <= i_d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign o_q = ff[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-domain pointer controller for the async FIFO: pointers, write strobe, full,
// fill level, almost-full and sticky overflow, against an internally synchronised read pointer.
module wr_ptr_ctrl
  import wr_ptr_ctrl_pkg::*;
#(
  parameter int PTR_WIDTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [PTR_WIDTH:0] i_g_rd_ptr,
  input  logic [PTR_WIDTH:0] i_af_thresh,
  input  logic               i_ovf_clr,
  output logic               o_wr_en,
  output logic [PTR_WIDTH:0] o_b_wr_ptr,
  output logic [PTR_WIDTH:0] o_g_wr_ptr,
  output logic               o_full,
  output logic               o_almost_full,
  output logic [PTR_WIDTH:0] o_level,
  output logic               o_overflow
);

  localparam int PW1 = PTR_WIDTH + 1;

  logic               acc;
  logic [PTR_WIDTH:0] rd_g_s, rd_b_s;
  logic [PTR_WIDTH:0] nxt_b, nxt_g, lvl_n, full_g;

  ptr_sync #(.WIDTH(PW1), .STAGES(SYNC_STAGES)) u_rd_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_g_rd_ptr),
    .o_q   (rd_g_s)
  );

  assign rd_b_s  = PW1'(gray2bin(32'(rd_g_s)));
  assign acc     = i_en & ~o_full;
  assign o_wr_en = acc;
  assign nxt_b   = o_b_wr_ptr + PW1'(acc);
  assign nxt_g   = PW1'(bin2gray(32'(nxt_b)));

  // Full in Gray: writer is one lap ahead when the top two bits differ and the rest match.
  assign full_g = {~rd_g_s[PTR_WIDTH:PTR_WIDTH-1], rd_g_s[PTR_WIDTH-2:0]};

  // Modular subtraction gives 0..DEPTH across pointer wrap; a stale read pointer only overstates.
  assign lvl_n = nxt_b - rd_b_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_b_wr_ptr    <= '0;
      o_g_wr_ptr    <= '0;
      o_full        <= 1'b0;
      o_level       <= '0;
      o_almost_full <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      o_b_wr_ptr    <= nxt_b;
      o_g_wr_ptr    <= nxt_g;
      o_full        <= (nxt_g == full_g);
      o_level       <= lvl_n;
      o_almost_full <= (lvl_n >= i_af_thresh);
      // A drop in the same cycle as a clear keeps the flag set.
      if (i_en && o_full)  o_overflow <= 1'b1;
      else if (i_ovf_clr)  o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Self-checking bench for wr_ptr_ctrl (PTR_WIDTH=3, SYNC_STAGES=2): cycle model feeds a
// scoreboard queue, plus fixed-value checks at the scenario boundaries.
module tb_wr_ptr_ctrl;

  typedef struct packed {
    logic [3:0] b;
    logic [3:0] g;
    logic       full;
    logic [3:0] lvl;
    logic       af;
    logic       ovf;
  } out_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_en = 1'b0;
  logic [3:0] i_g_rd_ptr = '0;
  logic [3:0] i_af_thresh = 4'hF;
  logic       i_ovf_clr = 1'b0;
  logic       o_wr_en, o_full, o_almost_full, o_overflow;
  logic [3:0] o_b_wr_ptr, o_g_wr_ptr, o_level;

  out_t obs, exp_o;
  out_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  logic [3:0] m_b, m_s0, m_s1, m_lvl;
  logic       m_full, m_af, m_ovf;

  wr_ptr_ctrl #(.PTR_WIDTH(3), .SYNC_STAGES(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_g_rd_ptr    (i_g_rd_ptr),
    .i_af_thresh   (i_af_thresh),
    .i_ovf_clr     (i_ovf_clr),
    .o_wr_en       (o_wr_en),
    .o_b_wr_ptr    (o_b_wr_ptr),
    .o_g_wr_ptr    (o_g_wr_ptr),
    .o_full        (o_full),
    .o_almost_full (o_almost_full),
    .o_level       (o_level),
    .o_overflow    (o_overflow)
  );

  assign obs = {o_b_wr_ptr, o_g_wr_ptr, o_full, o_level, o_almost_full, o_overflow};

  always #5 i_clk = ~i_clk;

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic model_clear();
    m_b = '0; m_s0 = '0; m_s1 = '0; m_lvl = '0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle, push the model's expectation, return #1 after the edge.
  task automatic step(input logic en, input logic clr);
    out_t       e;
    logic       acc;
    logic [3:0] nb;
    i_en = en;
    i_ovf_clr = clr;
    acc = en & ~m_full;
    nb = m_b + {3'b0, acc};
    e.b = nb;
    e.g = b2g(nb);
    e.lvl = nb - g2b(m_s1);
    e.full = (e.lvl == 4'd8);
    e.af = (e.lvl >= i_af_thresh);
    e.ovf = (en & m_full) | (~clr & m_ovf);
    m_s1 = m_s0; m_s0 = i_g_rd_ptr;
    m_b = nb; m_full = e.full; m_lvl = e.lvl; m_af = e.af; m_ovf = e.ovf;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    model_clear();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_g_rd_ptr = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0);
      exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin
        n_bad++; $display("FAIL reset_pre cyc%0d got=%h exp=%h", k, obs, exp_o);
      end
    end
    #2;
    i_rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== out_t'(0)) begin n_bad++; $display("FAIL reset_async got=%h exp=0", obs); end
    n_cmp++;
    if (o_wr_en !== 1'b1) begin n_bad++; $display("FAIL reset_wr_en got=%b exp=1", o_wr_en); end
    i_g_rd_ptr = '0;
    model_clear();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    // A stale sync chain would skew the first level after release.
    step(1'b1, 1'b0);
    exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o) begin n_bad++; $display("FAIL reset_post got=%h exp=%h", obs, exp_o); end
    n_cmp++;
    if (o_level !== 4'd1) begin n_bad++; $display("FAIL reset_sync_lvl got=%0d exp=1", o_level); end
  endtask

  task automatic test_fill();
    do_reset();
    i_g_rd_ptr = '0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0);
      exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin
        n_bad++; $display("FAIL fill cyc%0d got=%h exp=%h", k, obs, exp_o);
      end
      if (k == 7) begin
        n_cmp++;
        if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
          n_bad++; $display("FAIL fill_8th full=%b ovf=%b exp 1/0", o_full, o_overflow);
        end
      end
    end
    n_cmp++;
    if (o_b_wr_ptr !== 4'b1000 || o_g_wr_ptr !== 4'b1100 || o_level !== 4'd8 ||
        o_wr_en !== 1'b0 || o_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_end b=%b g=%b lvl=%0d wr_en=%b ovf=%b exp 1000/1100/8/0/1",
               o_b_wr_ptr, o_g_wr_ptr, o_level, o_wr_en, o_overflow);
    end
  endtask

  task automatic test_drain();
    i_g_rd_ptr = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin
        n_bad++; $display("FAIL drain cyc%0d got=%h exp=%h", k, obs, exp_o);
      end
      n_cmp++;
      if (k < 2 && o_full !== 1'b1) begin
        n_bad++; $display("FAIL drain_early cyc%0d full=%b exp=1", k, o_full);
      end else if (k == 2 && (o_full !== 1'b0 || o_level !== 4'd5)) begin
        n_bad++; $display("FAIL drain_3rd full=%b lvl=%0d exp 0/5", o_full, o_level);
      end
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    i_af_thresh = 4'd6;
    i_g_rd_ptr = '0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 1'b0);
      exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin
        n_bad++; $display("FAIL af_fill w%0d got=%h exp=%h", k, obs, exp_o);
      end
      n_cmp++;
      if (o_almost_full !== (k == 6)) begin
        n_bad++; $display("FAIL af_rise w%0d af=%b lvl=%0d", k, o_almost_full, o_level);
      end
    end
    i_g_rd_ptr = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin
        n_bad++; $display("FAIL af_read cyc%0d got=%h exp=%h", k, obs, exp_o);
      end
    end
    n_cmp++;
    if (o_almost_full !== 1'b0 || o_level !== 4'd5) begin
      n_bad++; $display("FAIL af_fall af=%b lvl=%0d exp 0/5", o_almost_full, o_level);
    end
    do_reset();
    i_af_thresh = 4'd0;
    i_g_rd_ptr = '0;
    step(1'b0, 1'b0);
    exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o || o_almost_full !== 1'b1) begin
      n_bad++; $display("FAIL af_thresh0 got=%h exp=%h", obs, exp_o);
    end
    i_af_thresh = 4'hF;
  endtask

  task automatic test_wrap();
    logic [3:0] pb, pg;
    logic [3:0] max_lvl;
    int         wraps;
    logic       saw_full;
    do_reset();
    i_af_thresh = 4'hF;
    i_g_rd_ptr = '0;
    pb = '0; pg = '0; max_lvl = '0; wraps = 0; saw_full = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k >= 2) i_g_rd_ptr = b2g(4'(k - 2));
      step(1'b1, 1'b0);
      exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin
        n_bad++; $display("FAIL wrap cyc%0d got=%h exp=%h", k, obs, exp_o);
      end
      if (pb == 4'd15 && o_b_wr_ptr == 4'd0 && pg == 4'b1000 && o_g_wr_ptr == 4'b0000) wraps++;
      if (o_full) saw_full = 1'b1;
      if (o_level > max_lvl) max_lvl = o_level;
      pb = o_b_wr_ptr; pg = o_g_wr_ptr;
    end
    n_cmp++;
    if (wraps != 2 || saw_full !== 1'b0 || max_lvl > 4'd5) begin
      n_bad++;
      $display("FAIL wrap_sum wraps=%0d full_seen=%b max_lvl=%0d exp 2/0/<=5", wraps, saw_full, max_lvl);
    end
  endtask

  task automatic test_ovf_clr();
    do_reset();
    i_g_rd_ptr = '0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0);
      exp_o = sb.pop_front(); n_cmp++;
      if (obs !== exp_o) begin
        n_bad++; $display("FAIL ovf_fill cyc%0d got=%h exp=%h", k, obs, exp_o);
      end
    end
    step(1'b1, 1'b1);
    exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o || o_overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set_wins got=%h exp=%h", obs, exp_o);
    end
    step(1'b0, 1'b1);
    exp_o = sb.pop_front(); n_cmp++;
    if (obs !== exp_o || o_overflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_clear got=%h exp=%h", obs, exp_o);
    end
    i_ovf_clr = 1'b0;
  endtask

  initial begin
    do_reset();
    test_reset();
    test_fill();
    test_drain();
    test_almost_full();
    test_wrap();
    test_ovf_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
